// File: rtl/riscv_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_cpu_pkg
// Description : Shared types and sizing constants for the data-memory slave.
//               Provides the data-bus width, byte-lane count, default RAM
//               depth and the grant-wait FSM state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_cpu_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int BE_WIDTH   = DATA_WIDTH / 8;
  localparam int DMEM_WORDS = 1024;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } dmem_state_e;

endpackage
`default_nettype wire

// File: rtl/data_ram_sp.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_sp
// Description : Synchronous single-port RAM, word organised, with per-byte
//               write enables. One read or one write per enabled cycle; read
//               data is registered and holds until the next read.
// Ports       : clk   - clock
//               en    - access enable for this cycle
//               we    - 1 = write, 0 = read
//               be    - byte-lane write enables (writes only)
//               addr  - word index
//               wdata - write data
//               rdata - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module data_ram_sp #(
  parameter int WORDS = 1024,
  parameter int DW    = 32,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [DW/8-1:0]   be,
  input  logic [AW-1:0]     addr,
  input  logic [DW-1:0]     wdata,
  output logic [DW-1:0]     rdata
);

  logic [DW-1:0] mem [WORDS];

  // No reset: contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < DW/8; i++) begin
          if (be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_ctrl
// Description : Data-memory slave terminating the LSU req/gnt/rvalid port.
//               Inserts GNT_WAIT grant wait states, performs one RAM access
//               per accepted request and returns exactly one response in the
//               cycle after acceptance. Out-of-range accesses get err = 1.
// Ports       : clk_i         - clock
//               rst_ni        - asynchronous active-low reset
//               data_req_i    - request valid
//               data_gnt_o    - request accepted (combinational)
//               data_rvalid_o - response valid, one-cycle pulse
//               data_addr_i   - byte address
//               data_we_i     - 1 = store, 0 = load
//               data_be_i     - store byte enables
//               data_wdata_i  - store data
//               data_rdata_o  - load data (0 for stores / errors)
//               data_err_o    - error flag, valid with rvalid
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
  parameter int DATA_WIDTH = riscv_cpu_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = riscv_cpu_pkg::DMEM_WORDS,
  parameter int GNT_WAIT   = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    data_req_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    data_err_o
);

  import riscv_cpu_pkg::*;

  localparam int         IDX_W     = $clog2(MEM_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'((GNT_WAIT > 0) ? (GNT_WAIT - 1) : 0);

  dmem_state_e           state;
  logic [3:0]            cnt;
  logic                  gnt;
  logic                  accept;
  logic                  in_range;
  logic                  ram_en;
  logic [IDX_W-1:0]      word_idx;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  rvalid;
  logic                  err;
  logic                  rsp_load;
  logic                  unused_addr_bits;

  // Byte offset within the word is not used for addressing.
  assign unused_addr_bits = ^data_addr_i[1:0];

  assign word_idx = data_addr_i[2 +: IDX_W];
  // In range iff every address bit above the RAM window is zero.
  assign in_range = (data_addr_i[ADDR_WIDTH-1:IDX_W+2] == '0);

  // Grant is combinational so that GNT_WAIT = 0 accepts in the request cycle.
  always_comb begin
    gnt = 1'b0;
    if (state == IDLE) begin
      if (GNT_WAIT == 0) begin
        gnt = data_req_i;
      end
    end else if (cnt == 4'd0) begin
      gnt = data_req_i;
    end
  end

  assign data_gnt_o = gnt;
  assign accept     = data_req_i & gnt;
  assign ram_en     = accept & in_range;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      rvalid   <= 1'b0;
      err      <= 1'b0;
      rsp_load <= 1'b0;
    end else begin
      rvalid <= accept;
      // Response qualifiers only change on accept so they hold between responses.
      if (accept) begin
        err      <= ~in_range;
        rsp_load <= in_range & ~data_we_i;
      end

      case (state)
        IDLE: begin
          if ((GNT_WAIT != 0) && data_req_i) begin
            state <= WAIT;
            cnt   <= WAIT_LOAD;
          end
        end
        WAIT: begin
          if (!data_req_i) begin
            // Request withdrawn before grant: abandon it silently.
            state <= IDLE;
            cnt   <= 4'd0;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // req && cnt == 0 means the request is accepted this edge.
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  data_ram_sp #(
    .WORDS (MEM_WORDS),
    .DW    (DATA_WIDTH),
    .AW    (IDX_W)
  ) u_ram (
    .clk   (clk_i),
    .en    (ram_en),
    .we    (data_we_i),
    .be    (data_be_i),
    .addr  (word_idx),
    .wdata (data_wdata_i),
    .rdata (ram_rdata)
  );

  assign data_rvalid_o = rvalid;
  assign data_err_o    = err;
  // RAM read register only updates on loads, so gating by rsp_load gives
  // zero for store/error responses and holds load data until the next one.
  assign data_rdata_o  = rsp_load ? ram_rdata : '0;

endmodule
`default_nettype wire
